i2s_rx: RTL and testbench
=========================

// Module: i2s_rx
// PURPOSE
//  I2S receiver for the codec ADC path (ADCDAT/ADCLRC/BCLK, codec is bus master).
//  Oversamples BCLK, LRCLK and SDATA in the clk domain, deserializes MSB-first
//  two's-complement words and publishes one stereo frame (left+right) per LRCLK
//  period via a valid/ready handshake. Mirror of i2s_tx on the DAC side.
// PARAMETERS
//  BITSIZE      16  bits captured per channel; slot bits beyond BITSIZE are ignored
//  SYNC_STAGES  2   synchronizer flops on bclk/lrclk/sdata (>=2)
// PORTS
//  clk            in   1        system clock; must be >= 4x BCLK frequency (target 49.152 MHz)
//  reset          in   1        async, active-high; clears all state
//  bclk           in   1        raw I2S bit clock (async to clk)
//  lrclk          in   1        raw word select: 0 = left, 1 = right
//  sdata          in   1        raw serial data
//  out_left       out  BITSIZE  left sample of last published frame
//  out_right      out  BITSIZE  right sample of last published frame
//  out_valid      out  1        frame available; held until accepted
//  out_ready      in   1        consumer accepts frame when high with out_valid
//  overrun        out  1        sticky: frame published while previous unaccepted
//  clear_overrun  in   1        synchronous clear of overrun
// BEHAVIOUR
//  - Reset (async): out_left=out_right=0, out_valid=0, overrun=0, FSM=SEEK, counters/shift reg 0.
//  - bclk, lrclk, sdata each pass SYNC_STAGES flops; one extra bclk flop gives
//    rise = bclk_s & ~bclk_d. All capture logic acts only in cycles where rise=1.
//  - On rise: sample lrclk_s and sdata_s; ws_chg = lrclk_s != ws_prev; ws_prev <= lrclk_s.
//  - I2S timing: rise with ws_chg carries the previous word's LSB (ignored); the
//    next BITSIZE rises carry MSB..LSB of the channel selected by the new lrclk.
//  - FSM (advances on rise only):
//    SEEK : wait for ws_chg; then bitcnt<=0, chan<=lrclk_s -> SHIFT.
//    SHIFT: shift sdata_s into shreg (MSB first), bitcnt++; if ws_chg first -> word
//           dropped, restart SHIFT for new channel (bitcnt<=0); when bitcnt reaches
//           BITSIZE -> latch word to hold_l/hold_r per chan -> HOLD.
//    HOLD : ignore data until ws_chg -> bitcnt<=0, chan<=lrclk_s -> SHIFT.
//  - left_ok set when a full left word latches; cleared on ws_chg into left and on
//    any dropped word. A full right word with left_ok=1 completes a frame.
//  - Frame publish: one clk after the completing rise, out_left<=hold_l,
//    out_right<=hold_r, out_valid<=1. Latency: SYNC_STAGES+2 clk edges from the first
//    edge sampling bclk high on the right-LSB bit to out_valid=1.
//  - Handshake: out_valid & out_ready at a clk edge -> out_valid<=0. Publish and
//    accept in same cycle -> out_valid stays 1, new data, no overrun.
//  - Publish while out_valid=1 and out_ready=0 -> data overwritten, overrun<=1.
//    overrun set and clear_overrun same cycle -> set wins.
//  - First frame after reset/SEEK needs a complete left then right word; a right
//    word without a preceding complete left word is never published.
//  - Reset mid-word: outputs clear immediately; resync via SEEK on release.
// TESTING
//  1 Assert reset mid-stream -> all outputs 0 within the same cycle; no publish until full L+R.
//  2 BITSIZE=16, 32-bit slots, L=16'hA5C3, R=16'h5A3C -> out_left=A5C3, out_right=5A3C,
//    out_valid=1 after SYNC_STAGES+2 clks; pulse out_ready -> out_valid=0, overrun=0.
//  3 Release reset during a right word -> that right word dropped; first frame = next full L+R.
//  4 Hold out_ready=0 across frames (1111,2222),(3333,4444) -> out=3333/4444, overrun=1;
//    clear_overrun -> 0; clear_overrun same cycle as new overrun -> overrun stays 1.
//  5 LRCLK toggles after 8 left bits -> frame not published; next full frame (0001,FFFF) is published.
//  6 out_ready high on the same clk as a publish -> out_valid stays 1 with new data, overrun=0.

Source files
------------

// File: rtl/i2s_rx.sv
// -----------------------------------------------------------------------------
// i2s_rx
//   I2S receiver for the codec ADC path. The codec is bus master, so bclk,
//   lrclk and sdata arrive asynchronous to clk and are oversampled here.
//   MSB-first two's-complement words are deserialized, and one stereo frame
//   (left then right) is published per lrclk period through a valid/ready
//   handshake. clk must run at least 4x the bclk frequency.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high; clears all state
//   bclk           raw I2S bit clock
//   lrclk          raw word select (0 = left, 1 = right)
//   sdata          raw serial data
//   out_left       left sample of the last published frame
//   out_right      right sample of the last published frame
//   out_valid      frame available; held until accepted
//   out_ready      consumer accepts the frame when high with out_valid
//   overrun        sticky; a frame was published over an unaccepted one
//   clear_overrun  synchronous clear of overrun (a same-cycle set wins)
// -----------------------------------------------------------------------------
module i2s_rx #(
  parameter int BITSIZE     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bclk,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [BITSIZE-1:0] out_left,
  output logic [BITSIZE-1:0] out_right,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overrun,
  input  logic               clear_overrun
);

  localparam int CNT_W = $clog2(BITSIZE + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITSIZE - 1);

  typedef enum logic [1:0] {
    SEEK,
    SHIFT,
    HOLD
  } state_t;

  // Synchronizers
  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrclk_sync;
  logic [SYNC_STAGES-1:0] sdata_sync;
  logic                   bclk_d;

  logic bclk_s;
  logic lrclk_s;
  logic sdata_s;
  logic rise;
  logic ws_chg;

  // Capture state
  state_t              state;
  logic                ws_prev;
  logic                chan;
  logic                left_ok;
  logic [CNT_W-1:0]    bitcnt;
  logic [BITSIZE-2:0]  shreg;
  logic [BITSIZE-1:0]  word_next;
  logic [BITSIZE-1:0]  hold_l;
  logic [BITSIZE-1:0]  hold_r;
  logic                frame_pub;

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, which the synchronizer
  // chains depend on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync  <= '0;
      lrclk_sync <= '0;
      sdata_sync <= '0;
      bclk_d     <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], lrclk};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
      bclk_d     <= bclk_s;
    end
  end

  assign bclk_s  = bclk_sync[SYNC_STAGES-1];
  assign lrclk_s = lrclk_sync[SYNC_STAGES-1];
  assign sdata_s = sdata_sync[SYNC_STAGES-1];
  assign rise    = bclk_s & ~bclk_d;
  assign ws_chg  = lrclk_s ^ ws_prev;

  // The shift register only keeps the first BITSIZE-1 bits; the last bit is
  // appended on the fly so the complete word can be latched on its own rise.
  assign word_next = {shreg, sdata_s};

  // Word capture FSM. Advances only on synchronized bclk rising edges.
  // The rise that carries a word-select change holds the previous word's LSB,
  // so a new word always starts on the rise after ws_chg.
  // NOTE: every register here, including the shift and hold registers, is
  // cleared by reset; they are plain flops, not a memory array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEEK;
      ws_prev   <= 1'b0;
      chan      <= 1'b0;
      left_ok   <= 1'b0;
      bitcnt    <= '0;
      shreg     <= '0;
      hold_l    <= '0;
      hold_r    <= '0;
      frame_pub <= 1'b0;
    end else begin
      frame_pub <= 1'b0;
      if (rise) begin
        ws_prev <= lrclk_s;
        case (state)
          SEEK, HOLD: begin
            if (ws_chg) begin
              bitcnt <= '0;
              chan   <= lrclk_s;
              state  <= SHIFT;
              // A new left word invalidates any earlier left sample.
              if (!lrclk_s) left_ok <= 1'b0;
            end
          end
          SHIFT: begin
            if (ws_chg) begin
              // Word cut short: drop it and restart on the new channel.
              bitcnt  <= '0;
              chan    <= lrclk_s;
              left_ok <= 1'b0;
            end else begin
              shreg  <= word_next[BITSIZE-2:0];
              bitcnt <= bitcnt + CNT_W'(1);
              if (bitcnt == LAST_BIT) begin
                if (chan) begin
                  hold_r <= word_next;
                  if (left_ok) frame_pub <= 1'b1;
                end else begin
                  hold_l  <= word_next;
                  left_ok <= 1'b1;
                end
                state <= HOLD;
              end
            end
          end
          default: state <= SEEK;
        endcase
      end
    end
  end

  // Frame publication and consumer handshake. A publish takes priority over an
  // accept in the same cycle, so new data stays valid without flagging overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_pub) begin
        out_left  <= hold_l;
        out_right <= hold_r;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (frame_pub && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx
//   Directed bench for i2s_rx. Drives I2S slots of 32 bclk periods (8 clk per
//   bclk period); data changes while bclk is low and is stable at each rise.
//   Inputs change on clk falling edges; outputs are sampled away from rises.
// -----------------------------------------------------------------------------
module tb_i2s_rx;

  localparam int BITSIZE   = 16;
  localparam int SYNC      = 2;
  localparam int HALF_BCLK = 40;

  logic               clk = 1'b0;
  logic               reset;
  logic               bclk;
  logic               lrclk;
  logic               sdata;
  logic [BITSIZE-1:0] out_left;
  logic [BITSIZE-1:0] out_right;
  logic               out_valid;
  logic               out_ready;
  logic               overrun;
  logic               clear_overrun;

  int checks = 0;
  int errors = 0;

  i2s_rx #(
    .BITSIZE    (BITSIZE),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .out_left     (out_left),
    .out_right    (out_right),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overrun      (overrun),
    .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Slot bit 0 carries the previous word's LSB (zero padding here), bits
  // 1..16 carry the word MSB first, the rest of the slot is zero padding.
  function automatic logic slot_data(input logic [15:0] w, input int i);
    if (i >= 1 && i <= 16) return w[16-i];
    return 1'b0;
  endfunction

  task automatic send_bits(input logic lr, input logic [15:0] w,
                           input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bclk  = 1'b0;
      lrclk = lr;
      sdata = slot_data(w, i);
      #HALF_BCLK;
      bclk = 1'b1;
      #HALF_BCLK;
    end
  endtask

  // Full left+right frame. The right LSB bit is driven by hand so the publish
  // edge (SYNC+2 clk edges after bclk rises) can be observed or targeted.
  // pulse: 0 none, 1 out_ready on the publish edge, 2 clear_overrun on it.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input bit lat_chk, input int pulse);
    send_bits(1'b0, l, 0, 31);
    send_bits(1'b1, r, 0, 15);
    bclk  = 1'b0;
    lrclk = 1'b1;
    sdata = r[0];
    #HALF_BCLK;
    bclk = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    #1;
    if (lat_chk) check("latency_pre", {31'd0, out_valid}, 32'd0);
    if (pulse == 1) out_ready = 1'b1;
    if (pulse == 2) clear_overrun = 1'b1;
    @(posedge clk);
    #1;
    out_ready     = 1'b0;
    clear_overrun = 1'b0;
    if (lat_chk) check("latency_post", {31'd0, out_valid}, 32'd1);
    #4;
    send_bits(1'b1, r, 17, 31);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    #4;
  endtask

  task automatic clear_ovr();
    clear_overrun = 1'b1;
    @(posedge clk);
    #1;
    clear_overrun = 1'b0;
    #4;
  endtask

  initial begin
    reset         = 1'b1;
    bclk          = 1'b0;
    lrclk         = 1'b0;
    sdata         = 1'b0;
    out_ready     = 1'b0;
    clear_overrun = 1'b0;
    #20;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_left", {16'd0, out_left}, 32'd0);
    check("rst_right", {16'd0, out_right}, 32'd0);
    reset = 1'b0;

    // Basic frame with latency and accept. A lone right word first must not publish.
    send_bits(1'b1, 16'h7E7E, 0, 31);
    check("prime_no_pub", {31'd0, out_valid}, 32'd0);
    send_frame(16'hA5C3, 16'h5A3C, 1'b1, 0);
    check("t2_left", {16'd0, out_left}, 32'h0000_A5C3);
    check("t2_right", {16'd0, out_right}, 32'h0000_5A3C);
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    check("t2_overrun", {31'd0, overrun}, 32'd0);
    accept();
    check("t2_accepted", {31'd0, out_valid}, 32'd0);
    check("t2_overrun_after", {31'd0, overrun}, 32'd0);

    // Accept on the same edge as a publish.
    send_frame(16'h1234, 16'h5678, 1'b0, 0);
    check("t6_first_valid", {31'd0, out_valid}, 32'd1);
    send_frame(16'h9ABC, 16'hDEF0, 1'b0, 1);
    check("t6_valid", {31'd0, out_valid}, 32'd1);
    check("t6_left", {16'd0, out_left}, 32'h0000_9ABC);
    check("t6_right", {16'd0, out_right}, 32'h0000_DEF0);
    check("t6_overrun", {31'd0, overrun}, 32'd0);
    accept();
    check("t6_accepted", {31'd0, out_valid}, 32'd0);

    // Overrun: two frames without accept, clear, then clear against a new set.
    send_frame(16'h1111, 16'h2222, 1'b0, 0);
    check("t4_first_overrun", {31'd0, overrun}, 32'd0);
    send_frame(16'h3333, 16'h4444, 1'b0, 0);
    check("t4_left", {16'd0, out_left}, 32'h0000_3333);
    check("t4_right", {16'd0, out_right}, 32'h0000_4444);
    check("t4_overrun", {31'd0, overrun}, 32'd1);
    clear_ovr();
    check("t4_cleared", {31'd0, overrun}, 32'd0);
    check("t4_still_valid", {31'd0, out_valid}, 32'd1);
    send_frame(16'h5555, 16'h6666, 1'b0, 2);
    check("t4_set_wins", {31'd0, overrun}, 32'd1);
    check("t4_left2", {16'd0, out_left}, 32'h0000_5555);
    clear_ovr();
    check("t4_cleared2", {31'd0, overrun}, 32'd0);
    accept();
    check("t4_accepted", {31'd0, out_valid}, 32'd0);

    // Left word cut after 8 bits: the following right word must not publish.
    send_bits(1'b0, 16'hBEEF, 0, 8);
    send_bits(1'b1, 16'h7777, 0, 31);
    check("t5_dropped", {31'd0, out_valid}, 32'd0);
    send_frame(16'h0001, 16'hFFFF, 1'b0, 0);
    check("t5_valid", {31'd0, out_valid}, 32'd1);
    check("t5_left", {16'd0, out_left}, 32'h0000_0001);
    check("t5_right", {16'd0, out_right}, 32'h0000_FFFF);

    // Reset mid-word clears outputs before the next clk edge.
    send_bits(1'b0, 16'h1357, 0, 9);
    reset = 1'b1;
    #1;
    check("t1_valid", {31'd0, out_valid}, 32'd0);
    check("t1_left", {16'd0, out_left}, 32'd0);
    check("t1_right", {16'd0, out_right}, 32'd0);
    check("t1_overrun", {31'd0, overrun}, 32'd0);
    #9;
    send_bits(1'b0, 16'h1357, 10, 31);

    // Release reset inside a right word: it is dropped, next full frame publishes.
    send_bits(1'b1, 16'h2468, 0, 10);
    reset = 1'b0;
    send_bits(1'b1, 16'h2468, 11, 31);
    check("t3_no_pub", {31'd0, out_valid}, 32'd0);
    check("t3_no_overrun", {31'd0, overrun}, 32'd0);
    send_frame(16'hCAFE, 16'hF00D, 1'b0, 0);
    check("t3_valid", {31'd0, out_valid}, 32'd1);
    check("t3_left", {16'd0, out_left}, 32'h0000_CAFE);
    check("t3_right", {16'd0, out_right}, 32'h0000_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
